regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard, successor to the single-write-port pipeline register file. It provides NRD combinational read ports with write-first bypass and NWR write ports with deterministic priority. A busy bit per register is set at issue and cleared at writeback. It sits between decode (reads, busy checks, allocation) and writeback (writes). It keeps the `ready`/`all_ready` commit handshake used by the pipeline's global stall logic.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file slice.
package regfile_pkg;

  parameter int RF_XLEN = 64;
  parameter int RF_NREG = 32;

  function automatic int AW(input int nreg);
    return $clog2(nreg);
  endfunction

  typedef logic [AW(RF_NREG)-1:0] rf_addr_t;
  typedef logic [RF_XLEN-1:0]     rf_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on allocation, cleared by writeback or flush,
// frozen while the pipeline holds its commit strobe.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          all_ready,
  input  logic                          flush,
  input  logic                          alloc_en,
  input  logic [AW(NREG)-1:0]           alloc_addr,
  input  logic [NREG-1:0]               wr_hit,
  input  logic [NRD-1:0][AW(NREG)-1:0]  ra,
  output logic [NRD-1:0]                rbusy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Alloc is applied after the writeback clear so a same-cycle alloc wins.
  always_comb begin
    busy_d = busy_q;
    if (!all_ready) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        busy_d = busy_q & ~wr_hit;
        if (alloc_en && !(ZERO_REG != 0 && alloc_addr == '0)) begin
          busy_d[alloc_addr] = 1'b1;
        end
      end
    end
    if (reset) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  // Readers see writeback clears but never their own cycle's alloc or flush.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rbusy[i] = busy_q[ra[i]] & (all_ready | ~wr_hit[ra[i]]);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, priority write merge,
// busy scoreboard and the ready/all_ready commit handshake.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD-1:0][AW(NREG)-1:0]  ra,
  output logic [NRD-1:0][XLEN-1:0]      rd,
  output logic [NRD-1:0]                rbusy,
  input  logic [NWR-1:0]                wen,
  input  logic [NWR-1:0][AW(NREG)-1:0]  wa,
  input  logic [NWR-1:0][XLEN-1:0]      wd,
  input  logic                          alloc_en,
  input  logic [AW(NREG)-1:0]           alloc_addr,
  input  logic                          flush,
  input  logic                          all_ready,
  output logic                          ready
);

  logic [XLEN-1:0] regs_q   [NREG];
  logic [XLEN-1:0] regs_d   [NREG];
  logic [XLEN-1:0] regs_nxt [NREG];
  logic [NREG-1:0] wr_hit;
  logic            ready_q;
  logic            ready_d;

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_comb begin
    regs_nxt = regs_q;
    wr_hit   = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && !(ZERO_REG != 0 && wa[j] == '0)) begin
        regs_nxt[wa[j]] = wd[j];
        wr_hit[wa[j]]   = 1'b1;
      end
    end
  end

  always_comb begin
    regs_d  = regs_q;
    ready_d = ~all_ready;
    if (!all_ready) begin
      regs_d = regs_nxt;
    end
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_d[r] = '0;
      end
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q  <= regs_d;
    ready_q <= ready_d;
  end

  // Bypass only in commit cycles; frozen writes are dropped and never seen.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      rd[i] = all_ready ? regs_q[ra[i]] : regs_nxt[ra[i]];
      if (ZERO_REG != 0 && ra[i] == '0) begin
        rd[i] = '0;
      end
    end
  end

  assign ready = ready_q;

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .all_ready  (all_ready),
    .flush      (flush),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_hit     (wr_hit),
    .ra         (ra),
    .rbusy      (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic,
// all expectations from an array-based reference model of the register file.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AWL  = 5;

  logic                       clk;
  logic                       reset_s;
  logic [NRD-1:0][AWL-1:0]    ra_s;
  logic [NRD-1:0][XLEN-1:0]   rd_s;
  logic [NRD-1:0]             rbusy_s;
  logic [NWR-1:0]             wen_s;
  logic [NWR-1:0][AWL-1:0]    wa_s;
  logic [NWR-1:0][XLEN-1:0]   wd_s;
  logic                       alloc_en_s;
  logic [AWL-1:0]             alloc_addr_s;
  logic                       flush_s;
  logic                       all_ready_s;
  logic                       ready_s;

  typedef struct {
    bit             reset;
    bit             all_ready;
    bit             flush;
    bit             alloc_en;
    logic [AWL-1:0] alloc_addr;
    logic [AWL-1:0] ra [NRD];
    bit             wen [NWR];
    logic [AWL-1:0] wa [NWR];
    rf_word_t       wd [NWR];
    bit             chk;
  } stim_t;

  typedef struct {
    rf_word_t rd [NRD];
    bit       rbusy [NRD];
    bit       ready;
    int       step;
  } exp_t;

  exp_t     exp_q [$];
  exp_t     mon_e;
  rf_word_t m_regs [NREG];
  bit       m_busy [NREG];
  bit       m_ready;
  int       n_cmp  = 0;
  int       n_fail = 0;
  int       step   = 0;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset      (reset_s),
    .ra         (ra_s),
    .rd         (rd_s),
    .rbusy      (rbusy_s),
    .wen        (wen_s),
    .wa         (wa_s),
    .wd         (wd_s),
    .alloc_en   (alloc_en_s),
    .alloc_addr (alloc_addr_s),
    .flush      (flush_s),
    .all_ready  (all_ready_s),
    .ready      (ready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The value a register receives this cycle: the highest-numbered port
  // aiming at it wins; register 0 is never written.
  function automatic bit lastWrite(input stim_t s, input int r, output rf_word_t v);
    v = '0;
    if (r == 0) return 1'b0;
    for (int j = NWR - 1; j >= 0; j--) begin
      if (s.wen[j] && int'(s.wa[j]) == r) begin
        v = s.wd[j];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset      = 1'b0;
    s.all_ready  = 1'b0;
    s.flush      = 1'b0;
    s.alloc_en   = 1'b0;
    s.alloc_addr = '0;
    for (int i = 0; i < NRD; i++) s.ra[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      s.wen[j] = 1'b0;
      s.wa[j]  = '0;
      s.wd[j]  = '0;
    end
    s.chk = 1'b1;
    return s;
  endfunction

  // Drive one cycle, queue what the outputs must be, then advance the model.
  task automatic applyStimulus(input stim_t s);
    exp_t     e;
    rf_word_t v;
    bit       hit;
    int       r;
    reset_s      = s.reset;
    all_ready_s  = s.all_ready;
    flush_s      = s.flush;
    alloc_en_s   = s.alloc_en;
    alloc_addr_s = s.alloc_addr;
    for (int i = 0; i < NRD; i++) ra_s[i] = s.ra[i];
    for (int j = 0; j < NWR; j++) begin
      wen_s[j] = s.wen[j];
      wa_s[j]  = s.wa[j];
      wd_s[j]  = s.wd[j];
    end
    if (s.chk) begin
      for (int i = 0; i < NRD; i++) begin
        r   = int'(s.ra[i]);
        hit = lastWrite(s, r, v);
        if (s.all_ready) hit = 1'b0;
        e.rd[i]    = (r == 0) ? '0 : (hit ? v : m_regs[r]);
        e.rbusy[i] = m_busy[r] && !hit;
      end
      e.ready = m_ready;
      e.step  = step;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (s.reset) begin
      for (int k = 0; k < NREG; k++) begin
        m_regs[k] = '0;
        m_busy[k] = 1'b0;
      end
      m_ready = 1'b0;
    end else if (s.all_ready) begin
      m_ready = 1'b0;
    end else begin
      for (int k = 1; k < NREG; k++) begin
        if (lastWrite(s, k, v)) begin
          m_regs[k] = v;
          m_busy[k] = 1'b0;
        end
      end
      if (s.flush) begin
        for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
      end else if (s.alloc_en && s.alloc_addr != 0) begin
        m_busy[s.alloc_addr] = 1'b1;
      end
      m_ready = 1'b1;
    end
    #1;
    step++;
  endtask

  task automatic checkOutput(input exp_t e);
    for (int i = 0; i < NRD; i++) begin
      n_cmp++;
      if (rd_s[i] !== e.rd[i]) begin
        n_fail++;
        $display("[TB] FAIL rd%0d step %0d: got %h expected %h", i, e.step, rd_s[i], e.rd[i]);
      end
      n_cmp++;
      if (rbusy_s[i] !== e.rbusy[i]) begin
        n_fail++;
        $display("[TB] FAIL rbusy%0d step %0d: got %b expected %b", i, e.step, rbusy_s[i], e.rbusy[i]);
      end
    end
    n_cmp++;
    if (ready_s !== e.ready) begin
      n_fail++;
      $display("[TB] FAIL ready step %0d: got %b expected %b", e.step, ready_s, e.ready);
    end
  endtask

  // Monitor: whatever the stimulus queued for this cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: stimulus did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [AWL-1:0] rndAddr();
    if ($urandom_range(0, 1) == 0) return AWL'($urandom_range(0, 7));
    return AWL'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    stim_t s;
    for (int k = 0; k < NREG; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
    m_ready = 1'b0;

    // Reset: state is unknown in the very first cycle, checked from the second.
    s = idle(); s.reset = 1'b1; s.chk = 1'b0; applyStimulus(s);
    s = idle(); s.reset = 1'b1; s.ra[0] = 5'd5; applyStimulus(s);

    // x5 write with same-cycle bypass, then from storage.
    s = idle(); s.ra[0] = 5'd5; s.wen[0] = 1'b1; s.wa[0] = 5'd5; s.wd[0] = 64'hDEAD; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd5; applyStimulus(s);

    // Two ports on x7: port 1 must win.
    s = idle(); s.ra[0] = 5'd7; s.ra[1] = 5'd7;
    s.wen[0] = 1'b1; s.wa[0] = 5'd7; s.wd[0] = 64'h11;
    s.wen[1] = 1'b1; s.wa[1] = 5'd7; s.wd[1] = 64'h22; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd7; applyStimulus(s);

    // x0 stays zero and never busy.
    s = idle(); s.wen[0] = 1'b1; s.wa[0] = 5'd0; s.wd[0] = 64'hFF; s.alloc_en = 1'b1; applyStimulus(s);
    s = idle(); s.ra[1] = 5'd0; applyStimulus(s);

    // x3 alloc, writeback clear, then alloc beating a same-cycle write.
    s = idle(); s.alloc_en = 1'b1; s.alloc_addr = 5'd3; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd3; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd3; s.wen[1] = 1'b1; s.wa[1] = 5'd3; s.wd[1] = 64'h3333; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd3; s.alloc_en = 1'b1; s.alloc_addr = 5'd3;
    s.wen[0] = 1'b1; s.wa[0] = 5'd3; s.wd[0] = 64'h4444; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd3; applyStimulus(s);

    // Flush beats a same-cycle alloc.
    s = idle(); s.alloc_en = 1'b1; s.alloc_addr = 5'd4; applyStimulus(s);
    s = idle(); s.alloc_en = 1'b1; s.alloc_addr = 5'd9; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd4; s.ra[1] = 5'd9; s.flush = 1'b1; s.alloc_en = 1'b1; s.alloc_addr = 5'd12; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd12; s.ra[1] = 5'd9; applyStimulus(s);

    // Freeze drops the write and clears ready.
    s = idle(); s.all_ready = 1'b1; s.ra[0] = 5'd8; s.wen[0] = 1'b1; s.wa[0] = 5'd8; s.wd[0] = 64'h55; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd8; applyStimulus(s);

    // Reset while x8 is busy and a write is in flight.
    s = idle(); s.alloc_en = 1'b1; s.alloc_addr = 5'd8; applyStimulus(s);
    s = idle(); s.reset = 1'b1; s.ra[0] = 5'd8; s.ra[1] = 5'd5; s.wen[0] = 1'b1; s.wa[0] = 5'd5; s.wd[0] = 64'h99; applyStimulus(s);
    s = idle(); s.ra[0] = 5'd8; s.ra[1] = 5'd5; applyStimulus(s);

    // Random traffic, biased toward low registers to force collisions.
    for (int n = 0; n < 500; n++) begin
      s = idle();
      s.reset      = ($urandom_range(0, 49) == 0);
      s.all_ready  = ($urandom_range(0, 3) == 0);
      s.flush      = ($urandom_range(0, 15) == 0);
      s.alloc_en   = ($urandom_range(0, 1) == 1);
      s.alloc_addr = rndAddr();
      for (int i = 0; i < NRD; i++) s.ra[i] = rndAddr();
      for (int j = 0; j < NWR; j++) begin
        s.wen[j] = ($urandom_range(0, 1) == 1);
        s.wa[j]  = rndAddr();
        s.wd[j]  = {$urandom(), $urandom()};
      end
      applyStimulus(s);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
